// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_LIM_9 = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_LIM_5 = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  // {min1, min0, sec1, sec0, cs1, cs0}, one BCD nibble each
  typedef logic [6*BCD_W-1:0] bcd_time_t;

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit with clamping load and a ripple borrow.
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load_en,
  input  logic [BCD_W-1:0] load_value,
  input  logic [BCD_W-1:0] limit,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out
);

  logic [BCD_W-1:0] q_reg;
  logic [BCD_W-1:0] q_next;

  always_comb begin
    q_next = q_reg;
    if (clear) begin
      q_next = '0;
    end else if (load_en) begin
      q_next = (load_value > limit) ? limit : load_value;
    end else if (borrow_in) begin
      // A zero digit wraps to its limit and hands the borrow upward
      q_next = (q_reg == '0) ? limit : q_reg - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign q          = q_reg;
  assign borrow_out = borrow_in & (q_reg == '0);

endmodule

// File: rtl/countdown_timer.sv
// mm:ss.cc BCD countdown timer with start/pause button and post-expiry alarm.
// Optional COUNTDOWN_BLINK_EN adds a blink output that toggles every 50 ticks in DONE.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int ALARM_TICKS = 200,
  parameter int TICK_CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             btn_start,
  input  logic             btn_clear,
  input  logic             load_en,
  input  logic [23:0]      load_value,
  output logic [BCD_W-1:0] cs0,
  output logic [BCD_W-1:0] cs1,
  output logic [BCD_W-1:0] sec0,
  output logic [BCD_W-1:0] sec1,
  output logic [BCD_W-1:0] min0,
  output logic [BCD_W-1:0] min1,
  output logic             running,
  output logic             done,
  output logic             alarm
`ifdef COUNTDOWN_BLINK_EN
  ,
  output logic             blink
`endif
);

  timer_state_t          state_reg;
  timer_state_t          state_next;
  logic [TICK_CNT_W-1:0] cnt_reg;
  logic [TICK_CNT_W-1:0] cnt_next;
  logic                  btn_d_reg;
  logic                  btn_edge;
  logic                  done_reg;
  logic                  done_next;
  logic                  running_reg;
  logic                  alarm_reg;
  logic                  digit_load;
  logic                  digit_dec;
  logic                  is_zero;
  logic                  is_one;
  bcd_time_t             cur_time;
  logic [6:0]            borrow;
  logic                  borrow_top_unused;

  assign btn_edge = btn_start & ~btn_d_reg;
  assign is_zero  = (cur_time == '0);
  assign is_one   = (cur_time == bcd_time_t'(1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    digit_load = 1'b0;
    digit_dec  = 1'b0;
    if (btn_clear) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_en) begin
            digit_load = 1'b1;
          end else if (btn_edge && !is_zero) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (btn_edge) begin
            state_next = PAUSE;
          end else if (tick) begin
            // Zero is tested before decrementing so the digits never wrap past 00:00.00
            if (is_zero) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              digit_dec = 1'b1;
              if (is_one) begin
                state_next = DONE;
                done_next  = 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (btn_edge) begin
            state_next = RUN;
          end
        end
        DONE: begin
          if (btn_edge) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (tick) begin
            if (cnt_reg == TICK_CNT_W'(ALARM_TICKS - 1)) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      btn_d_reg   <= 1'b1;
      done_reg    <= 1'b0;
      running_reg <= 1'b0;
      alarm_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      btn_d_reg   <= btn_start;
      done_reg    <= done_next;
      running_reg <= (state_next == RUN);
      alarm_reg   <= (state_next == DONE);
    end
  end

  assign borrow[0] = digit_dec;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_digit
      localparam logic [BCD_W-1:0] LIM = (gi == 3 || gi == 5) ? DIGIT_LIM_5 : DIGIT_LIM_9;
      bcd_down_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .clear      (btn_clear),
        .load_en    (digit_load),
        .load_value (load_value[gi*BCD_W +: BCD_W]),
        .limit      (LIM),
        .borrow_in  (borrow[gi]),
        .q          (cur_time[gi*BCD_W +: BCD_W]),
        .borrow_out (borrow[gi+1])
      );
    end
  endgenerate

  // A borrow out of min1 would mean underflow, which the zero check rules out
  assign borrow_top_unused = borrow[6];

  assign cs0     = cur_time[0*BCD_W +: BCD_W];
  assign cs1     = cur_time[1*BCD_W +: BCD_W];
  assign sec0    = cur_time[2*BCD_W +: BCD_W];
  assign sec1    = cur_time[3*BCD_W +: BCD_W];
  assign min0    = cur_time[4*BCD_W +: BCD_W];
  assign min1    = cur_time[5*BCD_W +: BCD_W];
  assign running = running_reg;
  assign done    = done_reg;
  assign alarm   = alarm_reg;

`ifdef COUNTDOWN_BLINK_EN
  localparam int BLINK_TICKS = 50;

  logic [5:0] blink_cnt_reg;
  logic       blink_reg;

  always_ff @(posedge clk) begin
    if (rst || state_next != DONE) begin
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else if (state_reg == DONE && tick) begin
      if (blink_cnt_reg == 6'(BLINK_TICKS - 1)) begin
        blink_cnt_reg <= '0;
        blink_reg     <= ~blink_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  assign blink = blink_reg;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus a randomized run
// compared against a centisecond-arithmetic reference model.
module tb_countdown_timer;

  localparam int ALARM = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic        clk = 1'b0;
  logic        rst, tick, btn_start, btn_clear, load_en;
  logic [23:0] load_value;
  logic [3:0]  cs0, cs1, sec0, sec1, min0, min1;
  logic        running, done, alarm;
`ifdef COUNTDOWN_BLINK_EN
  logic        blink;
`endif
  logic [23:0] dut_time;

  int errors = 0;
  int checks = 0;

  // Reference model: time held as total centiseconds
  int   m_total, m_st, m_acnt;
  logic m_btn_d, m_done;

  assign dut_time = {min1, min0, sec1, sec0, cs1, cs0};

  countdown_timer #(.ALARM_TICKS(ALARM), .TICK_CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_start  (btn_start),
    .btn_clear  (btn_clear),
    .load_en    (load_en),
    .load_value (load_value),
    .cs0        (cs0),
    .cs1        (cs1),
    .sec0       (sec0),
    .sec1       (sec1),
    .min0       (min0),
    .min1       (min1),
    .running    (running),
    .done       (done),
    .alarm      (alarm)
`ifdef COUNTDOWN_BLINK_EN
    ,
    .blink      (blink)
`endif
  );

  always #5 clk = ~clk;

  function automatic int to_cs(input logic [23:0] v);
    int d[6];
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(v[i*4 +: 4]);
      if (i == 3 || i == 5) begin
        if (d[i] > 5) d[i] = 5;
      end else begin
        if (d[i] > 9) d[i] = 9;
      end
    end
    return ((d[5] * 10 + d[4]) * 60 + d[3] * 10 + d[2]) * 100 + d[1] * 10 + d[0];
  endfunction

  function automatic logic [23:0] to_bcd(input int t);
    int cc, s, m;
    cc = t % 100;
    s  = (t / 100) % 60;
    m  = t / 6000;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  task automatic model_step();
    logic edge_s;
    edge_s  = btn_start & ~m_btn_d;
    m_btn_d = btn_start;
    m_done  = 1'b0;
    if (rst) begin
      m_total = 0; m_st = S_IDLE; m_acnt = 0; m_btn_d = 1'b1;
    end else if (btn_clear) begin
      m_total = 0; m_st = S_IDLE; m_acnt = 0;
    end else begin
      case (m_st)
        S_IDLE: begin
          if (load_en) m_total = to_cs(load_value);
          else if (edge_s && m_total != 0) m_st = S_RUN;
        end
        S_RUN: begin
          if (edge_s) m_st = S_PAUSE;
          else if (tick) begin
            if (m_total > 0) m_total = m_total - 1;
            if (m_total == 0) begin
              m_st = S_DONE; m_done = 1'b1;
            end
          end
        end
        S_PAUSE: if (edge_s) m_st = S_RUN;
        default: begin
          if (edge_s) begin
            m_st = S_IDLE; m_acnt = 0;
          end else if (tick) begin
            m_acnt = m_acnt + 1;
            if (m_acnt == ALARM) begin
              m_st = S_IDLE; m_acnt = 0;
            end
          end
        end
      endcase
    end
  endtask

  task automatic drive(input logic rs, tk, bs, bc, ld, input logic [23:0] lv);
    rst = rs; tick = tk; btn_start = bs; btn_clear = bc; load_en = ld; load_value = lv;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic tk, bs, bc, ld, input logic [23:0] lv);
    drive(1'b0, tk, bs, bc, ld, lv);
  endtask

  task automatic test_reset();
    repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    checks++; if (dut_time !== 24'h0) begin errors++; $display("FAIL rst_digits: got %h want 000000", dut_time); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running: got %b want 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL rst_alarm: got %b want 0", alarm); end
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 24'h000005);
    repeat (2) cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
    checks++; if (running !== 1'b0 || dut_time !== 24'h000005) begin
      errors++; $display("FAIL rst_held_btn: got running=%b digits=%h want running=0 digits=000005", running, dut_time);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    $display("test_reset complete");
  endtask

  task automatic test_expiry();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h000003);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL exp_start: got running=%b want 1", running); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (dut_time !== 24'h000002) begin errors++; $display("FAIL exp_tick1: got %h want 000002", dut_time); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (dut_time !== 24'h000001 || done !== 1'b0) begin
      errors++; $display("FAIL exp_tick2: got %h done=%b want 000001 done=0", dut_time, done);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if ({dut_time, done, alarm, running} !== {24'h0, 3'b110}) begin
      errors++; $display("FAIL exp_zero: got %h done=%b alarm=%b running=%b want 000000 1 1 0", dut_time, done, alarm, running);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (done !== 1'b0 || alarm !== 1'b1) begin
      errors++; $display("FAIL exp_done_pulse: got done=%b alarm=%b want done=0 alarm=1", done, alarm);
    end
    for (int i = 1; i <= ALARM; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      checks++; if (alarm !== (i < ALARM)) begin
        errors++; $display("FAIL exp_alarm_tick%0d: got alarm=%b want %b", i, alarm, (i < ALARM));
      end
    end
    $display("test_expiry complete");
  endtask

  task automatic test_borrow();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h010000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (dut_time !== 24'h005999) begin errors++; $display("FAIL borrow_chain: got %h want 005999", dut_time); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (dut_time !== 24'h005998) begin errors++; $display("FAIL borrow_next: got %h want 005998", dut_time); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    $display("test_borrow complete");
  endtask

  task automatic test_pause();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h001000);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
    checks++; if (running !== 1'b0 || dut_time !== 24'h001000) begin
      errors++; $display("FAIL pause_enter: got running=%b digits=%h want 0 001000", running, dut_time);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b1, 24'h000777);
    checks++; if (dut_time !== 24'h001000) begin errors++; $display("FAIL pause_frozen: got %h want 001000", dut_time); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_resume: got running=%b want 1", running); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (dut_time !== 24'h000999) begin errors++; $display("FAIL pause_after: got %h want 000999", dut_time); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    $display("test_pause complete");
  endtask

  task automatic test_clamp();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h7FABCD);
    checks++; if (dut_time !== 24'h595999) begin errors++; $display("FAIL clamp_load: got %h want 595999", dut_time); end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (running !== 1'b0 || alarm !== 1'b0 || dut_time !== 24'h0) begin
      errors++; $display("FAIL zero_start: got running=%b alarm=%b digits=%h want 0 0 000000", running, alarm, dut_time);
    end
    $display("test_clamp complete");
  endtask

  task automatic test_ack();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h000001);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ack_done: got done=%b want 1", done); end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL ack_alarm_on: got alarm=%b want 1", alarm); end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    checks++; if (alarm !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL ack_alarm_off: got alarm=%b running=%b want 0 0", alarm, running);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    $display("test_ack complete");
  endtask

  task automatic test_clear();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 24'h000500);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
    checks++; if (dut_time !== 24'h000498) begin errors++; $display("FAIL clear_pre: got %h want 000498", dut_time); end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
    checks++; if ({dut_time, running, done, alarm} !== {24'h0, 3'b000}) begin
      errors++; $display("FAIL clear_run: got %h running=%b done=%b alarm=%b want 000000 0 0 0", dut_time, running, done, alarm);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
      checks++; if (done !== 1'b0 || running !== 1'b0) begin
        errors++; $display("FAIL clear_quiet%0d: got done=%b running=%b want 0 0", i, done, running);
      end
    end
    $display("test_clear complete");
  endtask

  task automatic test_random();
    logic        bs, tk, bc, ld, rs;
    logic [23:0] lv;
    bs = 1'b0;
    for (int n = 0; n < 600; n++) begin
      tk = ($urandom_range(1, 0) == 1);
      if ($urandom_range(7, 0) == 0) bs = ~bs;
      bc = ($urandom_range(59, 0) == 0);
      ld = ($urandom_range(11, 0) == 0);
      rs = ($urandom_range(199, 0) == 0);
      lv = ($urandom_range(1, 0) == 1) ? {16'h0, 8'($urandom_range(255, 0))} : 24'($urandom);
      if (ld && m_st == S_IDLE && !bc && !rs) $display("random load %h at cycle %0d", lv, n);
      drive(rs, tk, bs, bc, ld, lv);
      checks++;
      if ({dut_time, running, done, alarm} !==
          {to_bcd(m_total), (m_st == S_RUN), m_done, (m_st == S_DONE)}) begin
        errors++;
        $display("FAIL random_%0d: got %h run=%b done=%b alarm=%b want %h run=%b done=%b alarm=%b",
                 n, dut_time, running, done, alarm, to_bcd(m_total), (m_st == S_RUN), m_done, (m_st == S_DONE));
      end
    end
    $display("test_random complete");
  endtask

  initial begin
    m_total = 0; m_st = S_IDLE; m_acnt = 0; m_btn_d = 1'b1; m_done = 1'b0;
    test_reset();
    test_expiry();
    test_borrow();
    test_pause();
    test_clamp();
    test_ack();
    test_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
